fc_result_argmax_reader: RTL



---
 rtl/fc_result_argmax_reader.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/fc_result_argmax_reader.sv
// fc_result_argmax_reader
// Walks the FC classifier result memory one word per beat and keeps a
// running top-1 score/index for every batch image. The per-image argmax is
// presented on a held valid/ready output once all real classes are scanned.
module fc_result_argmax_reader #(
  parameter int AF         = 3,
  parameter int BATCH      = 9,
  parameter int FOUT3      = 1000,
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 32,
  parameter int IDX_W      = $clog2(FOUT3)
) (
  input  logic                                     clk,
  input  logic                                     rst,
  input  logic                                     start,
  output logic                                     busy,
  input  logic [BATCH-1:0][AF-1:0][DATA_WIDTH-1:0] result_data,
  output logic [ADDR_WIDTH-1:0]                    result_rd_ADDR,
  input  logic                                     result_valid,
  output logic                                     result_ready,
  output logic [BATCH-1:0][IDX_W-1:0]              top_idx,
  output logic [BATCH-1:0][DATA_WIDTH-1:0]         top_val,
  output logic                                     top_valid,
  input  logic                                     top_ready
);

  localparam int NWORDS = (FOUT3 + AF - 1) / AF;
  // Two spare bits so addr*AF+lane of the last (padded) word never wraps
  // before it is compared against FOUT3.
  localparam int CW = IDX_W + 2;

  typedef enum logic [1:0] {
    S_IDLE,
    S_READ,
    S_HOLD
  } state_e;

  state_e state_q, state_d;

  logic busy_q, busy_d;
  logic ready_q, ready_d;
  logic tvalid_q, tvalid_d;

  logic [ADDR_WIDTH-1:0] addr_q;

  logic signed [DATA_WIDTH-1:0] max_q [BATCH];
  logic signed [DATA_WIDTH-1:0] max_d [BATCH];
  logic [IDX_W-1:0]             idx_q [BATCH];
  logic [IDX_W-1:0]             idx_d [BATCH];

  logic [BATCH-1:0][IDX_W-1:0]      top_idx_q;
  logic [BATCH-1:0][DATA_WIDTH-1:0] top_val_q;

  logic [CW-1:0] base_cls;
  logic [CW-1:0] cls;

  logic xfer;
  logic last_beat;

  // ready_q is high exactly while in READ, so it doubles as the READ flag.
  assign xfer      = ready_q && result_valid;
  assign last_beat = xfer && (addr_q == ADDR_WIDTH'(NWORDS - 1));

  // State register.
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic: start only counts in IDLE, last beat ends the scan,
  // the output handshake returns to IDLE.
  // NOTE: every combinational output gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start)     state_d = S_READ;
      S_READ:  if (last_beat) state_d = S_HOLD;
      S_HOLD:  if (top_ready) state_d = S_IDLE;
      default:                state_d = S_IDLE;
    endcase
  end

  // Output decode of the upcoming state; registered below so outputs come
  // straight from flops.
  always_comb begin
    busy_d   = (state_d != S_IDLE);
    ready_d  = (state_d == S_READ);
    tvalid_d = (state_d == S_HOLD);
  end

  // Registered handshake/status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q   <= 1'b0;
      ready_q  <= 1'b0;
      tvalid_q <= 1'b0;
    end else begin
      busy_q   <= busy_d;
      ready_q  <= ready_d;
      tvalid_q <= tvalid_d;
    end
  end

  // Word address: advances on each transfer, wraps to 0 after the last word.
  always_ff @(posedge clk) begin
    if (rst)            addr_q <= '0;
    else if (last_beat) addr_q <= '0;
    else if (xfer)      addr_q <= addr_q + ADDR_WIDTH'(1);
  end

  // Per-beat compare chain across lanes; ascending lanes with a strict
  // compare keep the lowest index on ties, padding classes are masked out.
  always_comb begin
    base_cls = CW'(addr_q) * CW'(AF);
    cls      = '0;
    for (int b = 0; b < BATCH; b++) begin
      max_d[b] = max_q[b];
      idx_d[b] = idx_q[b];
      for (int l = 0; l < AF; l++) begin
        cls = base_cls + CW'(l);
        if ((cls < CW'(FOUT3)) && ($signed(result_data[b][l]) > max_d[b])) begin
          max_d[b] = result_data[b][l];
          idx_d[b] = IDX_W'(cls);
        end
      end
    end
  end

  // Running accumulators: seeded on an accepted start, updated per beat.
  // NOTE: no reset here; these are always re-seeded before a scan uses
  // them, and leaving them out keeps the reset net off the datapath.
  always_ff @(posedge clk) begin
    if ((state_q == S_IDLE) && start) begin
      for (int b = 0; b < BATCH; b++) begin
        max_q[b] <= {1'b1, {(DATA_WIDTH-1){1'b0}}};
        idx_q[b] <= '0;
      end
    end else if (xfer) begin
      for (int b = 0; b < BATCH; b++) begin
        max_q[b] <= max_d[b];
        idx_q[b] <= idx_d[b];
      end
    end
  end

  // Result registers: captured with the final beat, held until the next run
  // completes.
  always_ff @(posedge clk) begin
    if (rst) begin
      top_idx_q <= '0;
      top_val_q <= '0;
    end else if (last_beat) begin
      for (int b = 0; b < BATCH; b++) begin
        top_idx_q[b] <= idx_d[b];
        top_val_q[b] <= max_d[b];
      end
    end
  end

  assign busy           = busy_q;
  assign result_ready   = ready_q;
  assign top_valid      = tvalid_q;
  assign result_rd_ADDR = addr_q;
  assign top_idx        = top_idx_q;
  assign top_val        = top_val_q;

endmodule
